// File: rtl/ir_servo_responder.sv
// IR beacon classifier and servo responder for the line-follow controller.
// Optional IR_DEBOUNCE_EN adds a 3-sample majority filter on the IR input.
module ir_servo_responder #(
  parameter int GATE_CYCLES  = 1_000_000,
  parameter int LO_MIN       = 8,
  parameter int LO_MAX       = 12,
  parameter int HI_MIN       = 90,
  parameter int HI_MAX       = 110,
  parameter int SERVO_PERIOD = 2_000_000,
  parameter int PW_NEUTRAL   = 150_000,
  parameter int PW_A         = 100_000,
  parameter int PW_B         = 200_000,
  parameter int HOLD_PERIODS = 50,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       ResetIRModule,
  input  logic       EnableIRModule,
  input  logic       IR,
  output logic       ServoPWM,
  output logic       IRModuleDone,
  output logic [1:0] BeaconClass,
  output logic       Busy
);

  localparam int PW = $clog2(SERVO_PERIOD + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_PERIODS + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [PW-1:0] PER_LAST  = PW'(SERVO_PERIOD - 1);
  localparam logic [PW-1:0] W_NEU     = PW'(PW_NEUTRAL);
  localparam logic [PW-1:0] W_A       = PW'(PW_A);
  localparam logic [PW-1:0] W_B       = PW'(PW_B);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [15:0]   C_LO_MIN  = 16'(LO_MIN);
  localparam logic [15:0]   C_LO_MAX  = 16'(LO_MAX);
  localparam logic [15:0]   C_HI_MIN  = 16'(HI_MIN);
  localparam logic [15:0]   C_HI_MAX  = 16'(HI_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_MEASURE, S_CLASSIFY, S_MOVE, S_RETURN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic ir_s1_q, ir_s1_d;
  logic ir_s2_q, ir_s2_d;
  logic ir_prev_q, ir_prev_d;
`ifdef IR_DEBOUNCE_EN
  logic ir_s3_q, ir_s3_d;
  logic ir_s4_q, ir_s4_d;
  logic ir_f_q, ir_f_d;
`endif
  logic          pwm_q, pwm_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] width_q, width_d;
  logic [PW-1:0] target_q, target_d;
  logic [15:0]   edge_q, edge_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    class_q, class_d;
  logic          done_q, done_d;

  logic ir_clean, ir_rise, wrap, is_lo, is_hi;

`ifdef IR_DEBOUNCE_EN
  assign ir_clean = ir_f_q;
`else
  assign ir_clean = ir_s2_q;
`endif
  assign ir_rise = ir_clean & ~ir_prev_q;
  assign wrap    = (per_q == PER_LAST);
  assign is_lo   = (edge_q >= C_LO_MIN) && (edge_q <= C_LO_MAX);
  assign is_hi   = (edge_q >= C_HI_MIN) && (edge_q <= C_HI_MAX);

  // state register
  always_ff @(posedge clk or posedge ResetIRModule) begin
    if (ResetIRModule) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  // next-state: sequence steps, abort on enable loss outside DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (EnableIRModule) state_d = S_MEASURE;
      S_MEASURE:
        if (!EnableIRModule)       state_d = S_IDLE;
        else if (gate_q == GATE_LAST) state_d = S_CLASSIFY;
      S_CLASSIFY:
        if (!EnableIRModule)       state_d = S_IDLE;
        else if (is_lo || is_hi)   state_d = S_MOVE;
        else if (retry_q < RETRY_MAX) state_d = S_MEASURE;
        else                       state_d = S_DONE;
      S_MOVE:
        if (!EnableIRModule)       state_d = S_IDLE;
        else if (wrap && hold_q == HOLD_LAST) state_d = S_RETURN;
      S_RETURN:
        if (!EnableIRModule)       state_d = S_IDLE;
        else if (wrap && hold_q == HOLD_LAST) state_d = S_DONE;
      S_DONE:
        state_d = S_DONE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // outputs decoded from registered state and datapath
  always_comb begin
    Busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    ServoPWM     = pwm_q;
    IRModuleDone = done_q;
    BeaconClass  = class_q;
  end

  // datapath next values: IR front end, PWM, counters, result
  always_comb begin
    ir_s1_d   = IR;
    ir_s2_d   = ir_s1_q;
    ir_prev_d = ir_clean;
`ifdef IR_DEBOUNCE_EN
    ir_s3_d   = ir_s2_q;
    ir_s4_d   = ir_s3_q;
    ir_f_d    = (ir_s2_q & ir_s3_q) | (ir_s2_q & ir_s4_q) |
                (ir_s3_q & ir_s4_q);
`endif
    per_d    = wrap ? '0 : per_q + 1'b1;
    width_d  = wrap ? target_q : width_q;
    pwm_d    = (per_q < width_q);
    target_d = target_q;
    class_d  = class_q;
    edge_d   = edge_q;
    gate_d   = gate_q;
    retry_d  = retry_q;
    hold_d   = hold_q;
    done_d   = (state_q == S_DONE);

    if (state_q == S_MEASURE) begin
      gate_d = gate_q + 1'b1;
      if (ir_rise && edge_q != 16'hFFFF) edge_d = edge_q + 1'b1;
    end
    if (state_d == S_MEASURE && state_q != S_MEASURE) begin
      edge_d = '0;
      gate_d = '0;
    end
    if (state_q == S_IDLE) retry_d = '0;
    if (state_q == S_CLASSIFY && state_d == S_MEASURE)
      retry_d = retry_q + 1'b1;

    if (state_d != state_q) hold_d = '0;
    else if ((state_q == S_MOVE || state_q == S_RETURN) && wrap)
      hold_d = hold_q + 1'b1;

    if (state_q == S_CLASSIFY && state_d == S_MOVE) begin
      target_d = is_lo ? W_A : W_B;
      class_d  = is_lo ? 2'd1 : 2'd2;
    end
    if (state_q == S_CLASSIFY && state_d == S_DONE) class_d = 2'd3;
    if (state_q == S_MOVE && state_d == S_RETURN) target_d = W_NEU;
    if (state_q != S_IDLE && state_d == S_IDLE)   target_d = W_NEU;
  end

  // datapath registers
  always_ff @(posedge clk or posedge ResetIRModule) begin
    if (ResetIRModule) begin
      ir_s1_q   <= 1'b0;
      ir_s2_q   <= 1'b0;
      ir_prev_q <= 1'b0;
`ifdef IR_DEBOUNCE_EN
      ir_s3_q   <= 1'b0;
      ir_s4_q   <= 1'b0;
      ir_f_q    <= 1'b0;
`endif
      pwm_q     <= 1'b0;
      per_q     <= '0;
      width_q   <= W_NEU;
      target_q  <= W_NEU;
      edge_q    <= '0;
      gate_q    <= '0;
      hold_q    <= '0;
      retry_q   <= '0;
      class_q   <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      ir_s1_q   <= ir_s1_d;
      ir_s2_q   <= ir_s2_d;
      ir_prev_q <= ir_prev_d;
`ifdef IR_DEBOUNCE_EN
      ir_s3_q   <= ir_s3_d;
      ir_s4_q   <= ir_s4_d;
      ir_f_q    <= ir_f_d;
`endif
      pwm_q     <= pwm_d;
      per_q     <= per_d;
      width_q   <= width_d;
      target_q  <= target_d;
      edge_q    <= edge_d;
      gate_q    <= gate_d;
      hold_q    <= hold_d;
      retry_q   <= retry_d;
      class_q   <= class_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ir_servo_responder.sv
// Randomized bench for ir_servo_responder with a window-count model.
// Build with or without IR_DEBOUNCE_EN; glitch expectations follow it.
module tb_ir_servo_responder;

  localparam int G    = 1000;
  localparam int P    = 200;
  localparam int HOLD = 2;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ir;
  logic       pwm;
  logic       done;
  logic       busy;
  logic [1:0] cls;

  int n_chk  = 0;
  int n_pass = 0;
  int n_a, n_b, n_n, n_x, run;
  int cyc;
  int ir_mode = 0;
  int ir_p    = 100;
  int ir_ph   = 0;
  int ir_gl   = 0;

  always #5 clk = ~clk;

  ir_servo_responder #(
    .GATE_CYCLES(G), .SERVO_PERIOD(P), .PW_NEUTRAL(15),
    .PW_A(10), .PW_B(20), .HOLD_PERIODS(HOLD)
  ) dut (
    .clk(clk), .ResetIRModule(rst), .EnableIRModule(en),
    .IR(ir), .ServoPWM(pwm), .IRModuleDone(done),
    .BeaconClass(cls), .Busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // spec rule: class from edges in one window; same count every retry
  function automatic int exp_class(input int edges);
    if (edges >= 8 && edges <= 12) return 1;
    if (edges >= 90 && edges <= 110) return 2;
    return 3;
  endfunction

  function automatic int exp_edges(input int mode, input int p,
                                   input int gl);
    int e;
    e = (mode != 0) ? G / p : 0;
`ifndef IR_DEBOUNCE_EN
    if (gl != 0) e += G / 100;
`endif
    return e;
  endfunction

  // IR stimulus: square wave with optional 1-cycle glitches
  initial begin
    int t;
    ir  = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ir_mode != 0) begin
        t  = (cyc + ir_ph) % ir_p;
        ir = (t < ir_p / 2);
        if (ir_gl != 0 && (cyc + ir_ph) % 100 == 75) ir = 1'b1;
      end else begin
        ir = 1'b0;
      end
    end
  end

  // servo pulse-width histogram
  initial begin
    run = 0;
    n_a = 0; n_b = 0; n_n = 0; n_x = 0;
    forever begin
      @(negedge clk);
      if (pwm === 1'b1) run++;
      else if (run > 0) begin
        case (run)
          10:      n_a++;
          20:      n_b++;
          15:      n_n++;
          default: n_x++;
        endcase
        run = 0;
      end
    end
  end

  task automatic clear_counts();
    n_a = 0; n_b = 0; n_n = 0; n_x = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_counts();
  endtask

  task automatic run_case(input string tag, input int mode,
                          input int p, input int ph, input int gl);
    int  e, c, lat, win;
    bit  ok;
    do_reset();
    ir_mode = mode; ir_p = p; ir_ph = ph; ir_gl = gl;
    e   = exp_edges(mode, p, gl);
    c   = exp_class(e);
    win = (c == 3) ? MAXR + 1 : 1;
    repeat (5) @(negedge clk);
    en  = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (i == 3) check({tag, "_busy_run"}, busy, 1);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_class"}, cls, c);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_pw_a"}, n_a, (c == 1) ? HOLD : 0);
    check({tag, "_pw_b"}, n_b, (c == 2) ? HOLD : 0);
    check({tag, "_pw_bad"}, n_x, 0);
    if (c == 3)
      check({tag, "_lat"}, lat, win * (G + 1) + 2);
    else begin
      check({tag, "_lat_min"}, lat > G + 1, 1);
      check({tag, "_lat_max"},
            lat <= win * (G + 1) + 2 * HOLD * P + P + 3, 1);
    end
  endtask

  int per_tab[9] = '{10, 20, 25, 40, 50, 100, 125, 200, 250};

  initial begin
    bit ok;
    int k;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_class", cls, 0);
    check("rst_busy", busy, 0);
    check("rst_pwm", pwm, 0);
    rst = 1'b0;

    run_case("low", 1, 100, 0, 0);
    run_case("high", 1, 10, 3, 0);
    run_case("none", 0, 100, 0, 0);
    run_case("glitch", 1, 100, $urandom_range(0, 99), 1);

    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 9);
      if (k == 9) run_case("rnd", 0, 100, 0, 0);
      else run_case("rnd", 1, per_tab[k],
                    $urandom_range(0, per_tab[k] - 1), 0);
    end

    // enable dropped during MOVE
    do_reset();
    ir_mode = 1; ir_p = 100; ir_ph = $urandom_range(0, 99); ir_gl = 0;
    en = 1'b1;
    for (int i = 0; i < 5000 && n_a < 1; i++) @(negedge clk);
    check("abort_in_move", n_a >= 1, 1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    clear_counts();
    repeat (700) @(negedge clk);
    check("abort_pw_a", n_a, 0);
    check("abort_pw_bad", n_x, 0);
    check("abort_neutral", n_n >= 3, 1);
    check("abort_class", cls, 1);
    check("abort_done_late", done, 0);

    // reset while in DONE with the pulse high
    run_case("pre_rst", 1, 10, 0, 0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pwm === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_pwm_high", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm", pwm, 0);
    check("arst_done", done, 0);
    check("arst_class", cls, 0);
    run_case("post_rst", 1, 100, 7, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
